// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and address map for the data RAM bus arbiter and the ram module.
package ram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } arb_state_t;

    // RAM window and the read-only status byte inside it
    localparam logic [7:0] RAM_BASE_ADDR   = 8'h00;
    localparam logic [7:0] RAM_LAST_ADDR   = 8'h7F;
    localparam logic [7:0] RAM_STATUS_ADDR = 8'h00;

endpackage

// File: rtl/ram_req_filter.sv
// Combinational legality check for the request currently selected onto the RAM bus.
module ram_req_filter
    import ram_bus_arbiter_pkg::*;
(
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] base_addr,
    input  logic [7:0] last_addr,
    input  logic [7:0] status_addr,
    output logic       legal,
    output logic       wr_ok,
    output logic       rd_ok
);

    // Window bounds arrive as ports so the same filter serves any address map.
    assign legal = (addr >= base_addr) && (addr <= last_addr) && !(we && (addr == status_addr));
    assign wr_ok = req && legal && we;
    assign rd_ok = req && legal && !we;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the single-port data RAM between the CPU and a DMA master, with
// starvation override, bounded bus locking and illegal-access rejection.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = RAM_BASE_ADDR,
    parameter logic [7:0]  LAST_ADDR    = RAM_LAST_ADDR,
    parameter logic [7:0]  STATUS_ADDR  = RAM_STATUS_ADDR,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_lock,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       cpu_err,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    input  logic       dma_lock,
    output logic       dma_gnt,
    output logic       dma_rvalid,
    output logic [7:0] dma_rdata,
    output logic       dma_err,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_wr_en,
    output logic       ram_rd_en,
    input  logic [7:0] ram_rdata
);

    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);
    localparam logic [3:0] LOCK_LAST  = 4'(LOCK_MAX - 1);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic [3:0] lock_cnt;
    logic       cpu_rd_pend;
    logic       dma_rd_pend;

    logic       sel_dma;
    logic       sel_req;
    logic       sel_we;
    logic       sel_lock;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;
    logic       legal;
    logic       wr_ok;
    logic       rd_ok;
    logic       starving;
    logic       keep_lock;

    // The owner's request is muxed once and checked by a single filter.
    assign sel_dma   = (state == OWN_DMA);
    assign sel_req   = sel_dma ? dma_req   : cpu_req;
    assign sel_we    = sel_dma ? dma_we    : cpu_we;
    assign sel_lock  = sel_dma ? dma_lock  : cpu_lock;
    assign sel_addr  = sel_dma ? dma_addr  : cpu_addr;
    assign sel_wdata = sel_dma ? dma_wdata : cpu_wdata;

    assign starving  = (starve_cnt >= STARVE_THR);
    assign keep_lock = sel_lock && sel_req && (lock_cnt < LOCK_LAST)
                       && !((state == OWN_CPU) && starving);

    ram_req_filter u_filter (
        .req         (sel_req),
        .we          (sel_we),
        .addr        (sel_addr),
        .base_addr   (BASE_ADDR),
        .last_addr   (LAST_ADDR),
        .status_addr (STATUS_ADDR),
        .legal       (legal),
        .wr_ok       (wr_ok),
        .rd_ok       (rd_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            lock_cnt    <= 4'd0;
            cpu_rd_pend <= 1'b0;
            dma_rd_pend <= 1'b0;
            cpu_gnt     <= 1'b0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= 8'd0;
            cpu_err     <= 1'b0;
            dma_gnt     <= 1'b0;
            dma_rvalid  <= 1'b0;
            dma_rdata   <= 8'd0;
            dma_err     <= 1'b0;
            ram_addr    <= 8'd0;
            ram_wdata   <= 8'd0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
        end else begin
            cpu_gnt     <= 1'b0;
            dma_gnt     <= 1'b0;
            cpu_err     <= 1'b0;
            dma_err     <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
            cpu_rd_pend <= 1'b0;
            dma_rd_pend <= 1'b0;

            // Read data comes back the cycle after the grant, while ram_rd_en is high.
            cpu_rvalid <= cpu_rd_pend;
            dma_rvalid <= dma_rd_pend;
            if (cpu_rd_pend) cpu_rdata <= ram_rdata;
            if (dma_rd_pend) dma_rdata <= ram_rdata;

            if (dma_req && !dma_gnt)
                starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;

            case (state)
                IDLE: begin
                    lock_cnt <= 4'd0;
                    if (dma_req && starving) state <= OWN_DMA;
                    else if (cpu_req)        state <= OWN_CPU;
                    else if (dma_req)        state <= OWN_DMA;
                end
                OWN_CPU, OWN_DMA: begin
                    if (sel_req) begin
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_wr_en <= wr_ok;
                        ram_rd_en <= rd_ok;
                        if (sel_dma) begin
                            dma_gnt     <= 1'b1;
                            dma_err     <= !legal;
                            dma_rd_pend <= rd_ok;
                        end else begin
                            cpu_gnt     <= 1'b1;
                            cpu_err     <= !legal;
                            cpu_rd_pend <= rd_ok;
                        end
                    end
                    // Leaving always passes through IDLE, so owners never switch back-to-back.
                    if (keep_lock) begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end else begin
                        lock_cnt <= 4'd0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized self-checking bench for ram_bus_arbiter against a transaction-level model.
module tb_ram_bus_arbiter;

    localparam int STARVE = 4;
    localparam int LOCKS  = 8;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       lock;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
    logic [7:0] cpu_addr = 8'd0, cpu_wdata = 8'd0;
    logic       dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [7:0] dma_addr = 8'd0, dma_wdata = 8'd0;
    logic       cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
    logic [7:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
    logic       ram_wr_en, ram_rd_en;

    logic [7:0] ram_mem [256];
    logic       init_en = 1'b1;
    logic       check_en = 1'b0;
    logic       rand_mode = 1'b0;
    int         checks = 0;
    int         errors = 0;
    txn_t       cpu_q[$];
    txn_t       dma_q[$];

    // Model state: owner 0=none 1=cpu 2=dma, plus expected registered outputs.
    int         m_own = 0, m_burst = 0, m_starve = 0;
    logic       m_pend_cpu = 1'b0, m_pend_dma = 1'b0;
    logic [7:0] m_pend_val = 8'd0;
    logic [7:0] m_mem [256];
    logic       e_cpu_gnt = 1'b0, e_cpu_rvalid = 1'b0, e_cpu_err = 1'b0;
    logic       e_dma_gnt = 1'b0, e_dma_rvalid = 1'b0, e_dma_err = 1'b0;
    logic       e_wr = 1'b0, e_rd = 1'b0;
    logic [7:0] e_cpu_rdata = 8'd0, e_dma_rdata = 8'd0, e_addr = 8'd0, e_wdata = 8'd0;

    ram_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_lock   (cpu_lock),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_err    (dma_err),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wr_en  (ram_wr_en),
        .ram_rd_en  (ram_rd_en),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : 8'(a * 7 + 3);
    endfunction

    // Environment RAM with combinational read.
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(8'(i));
        end else if (ram_wr_en) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Applies the arbitration rules to the inputs present at this clock edge.
    task automatic model_step();
        int         next_starve;
        logic       req, we, lock, bad;
        logic [7:0] a, d;
        if (reset) begin
            m_own = 0; m_burst = 0; m_starve = 0; m_pend_cpu = 0; m_pend_dma = 0;
            {e_cpu_gnt, e_cpu_rvalid, e_cpu_err, e_dma_gnt, e_dma_rvalid, e_dma_err, e_wr, e_rd} = '0;
            e_cpu_rdata = 0; e_dma_rdata = 0; e_addr = 0; e_wdata = 0;
        end else begin
            e_cpu_rvalid = m_pend_cpu;
            e_dma_rvalid = m_pend_dma;
            if (m_pend_cpu) e_cpu_rdata = m_pend_val;
            if (m_pend_dma) e_dma_rdata = m_pend_val;
            m_pend_cpu = 0; m_pend_dma = 0;
            next_starve = (dma_req && !e_dma_gnt) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            {e_cpu_gnt, e_cpu_err, e_dma_gnt, e_dma_err, e_wr, e_rd} = '0;
            if (m_own == 0) begin
                if (dma_req && m_starve >= STARVE) m_own = 2;
                else if (cpu_req)                  m_own = 1;
                else if (dma_req)                  m_own = 2;
                m_burst = 0;
            end else begin
                req  = (m_own == 1) ? cpu_req   : dma_req;
                we   = (m_own == 1) ? cpu_we    : dma_we;
                lock = (m_own == 1) ? cpu_lock  : dma_lock;
                a    = (m_own == 1) ? cpu_addr  : dma_addr;
                d    = (m_own == 1) ? cpu_wdata : dma_wdata;
                if (req) begin
                    bad = (a > 8'h7F) || (we && a == 8'h00);
                    e_addr = a; e_wdata = d;
                    if (m_own == 1) begin e_cpu_gnt = 1; e_cpu_err = bad; end
                    else            begin e_dma_gnt = 1; e_dma_err = bad; end
                    if (!bad && we) begin
                        e_wr = 1; m_mem[a] = d;
                    end else if (!bad) begin
                        e_rd = 1; m_pend_val = m_mem[a];
                        m_pend_cpu = (m_own == 1); m_pend_dma = (m_own == 2);
                    end
                end
                if (req && lock && m_burst < LOCKS - 1 && !(m_own == 1 && m_starve >= STARVE))
                    m_burst++;
                else begin
                    m_burst = 0; m_own = 0;
                end
            end
            m_starve = next_starve;
        end
    endtask

    task automatic drive_masters();
        cpu_req = (cpu_q.size() != 0);
        dma_req = (dma_q.size() != 0);
        if (cpu_req) {cpu_we, cpu_addr, cpu_wdata, cpu_lock} = {cpu_q[0].we, cpu_q[0].addr, cpu_q[0].wdata, cpu_q[0].lock};
        else         {cpu_we, cpu_addr, cpu_wdata, cpu_lock} = '0;
        if (dma_req) {dma_we, dma_addr, dma_wdata, dma_lock} = {dma_q[0].we, dma_q[0].addr, dma_q[0].wdata, dma_q[0].lock};
        else         {dma_we, dma_addr, dma_wdata, dma_lock} = '0;
    endtask

    task automatic update_masters();
        if (e_cpu_gnt) cpu_q.delete(0);
        else if (rand_mode && cpu_q.size() != 0 && $urandom_range(0, 39) == 0) cpu_q.delete(0);
        if (e_dma_gnt) dma_q.delete(0);
        else if (rand_mode && dma_q.size() != 0 && $urandom_range(0, 39) == 0) dma_q.delete(0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        update_masters();
        drive_masters();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d, input logic lock);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.lock = lock;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [7:0] a;
        a = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
        return mk(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 2) == 0));
    endfunction

    task automatic count_until_dma(output int cpu_before, output int last_cpu, output int dma_at);
        cpu_before = 0; last_cpu = -1; dma_at = -1;
        for (int i = 0; i < 30 && dma_at < 0; i++) begin
            tick();
            if (cpu_gnt) begin cpu_before++; last_cpu = i; end
            if (dma_gnt) dma_at = i;
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("cpu_gnt",    8'(cpu_gnt),    8'(e_cpu_gnt));
            check_output("cpu_err",    8'(cpu_err),    8'(e_cpu_err));
            check_output("cpu_rvalid", 8'(cpu_rvalid), 8'(e_cpu_rvalid));
            check_output("cpu_rdata",  cpu_rdata,      e_cpu_rdata);
            check_output("dma_gnt",    8'(dma_gnt),    8'(e_dma_gnt));
            check_output("dma_err",    8'(dma_err),    8'(e_dma_err));
            check_output("dma_rvalid", 8'(dma_rvalid), 8'(e_dma_rvalid));
            check_output("dma_rdata",  dma_rdata,      e_dma_rdata);
            check_output("ram_wr_en",  8'(ram_wr_en),  8'(e_wr));
            check_output("ram_rd_en",  8'(ram_rd_en),  8'(e_rd));
            check_output("ram_addr",   ram_addr,       e_addr);
            check_output("ram_wdata",  ram_wdata,      e_wdata);
            check_output("gnt_exclusive", 8'(cpu_gnt & dma_gnt), 8'd0);
        end
    end

    initial begin
        int cb, lc, da, cnt_ce, cnt_de, cnt_str, cnt_rv;
        int g[$];
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(8'(i));
        tick();
        tick();
        reset = 1'b0; init_en = 1'b0; check_en = 1'b1;
        check_output("reset_cpu_gnt",   8'(cpu_gnt),   8'd0);
        check_output("reset_ram_rd_en", 8'(ram_rd_en), 8'd0);
        check_output("reset_ram_addr",  ram_addr,      8'd0);
        check_output("reset_cpu_rdata", cpu_rdata,     8'd0);
        idle_cycles(2);

        // CPU read of 0x10: grant two cycles out, data one cycle after that.
        cpu_q.push_back(mk(1'b0, 8'h10, 8'h00, 1'b0));
        drive_masters();
        tick();
        check_output("t1_gnt_early", 8'(cpu_gnt), 8'd0);
        tick();
        check_output("t1_gnt",      8'(cpu_gnt),   8'd1);
        check_output("t1_rd_en",    8'(ram_rd_en), 8'd1);
        check_output("t1_ram_addr", ram_addr,      8'h10);
        tick();
        check_output("t1_rvalid",   8'(cpu_rvalid), 8'd1);
        check_output("t1_rdata",    cpu_rdata,      8'hA5);
        check_output("t1_rd_en_off", 8'(ram_rd_en), 8'd0);
        idle_cycles(4);

        // CPU requests continuously, DMA waits for the starvation override.
        for (int k = 0; k < 6; k++) cpu_q.push_back(mk(1'b0, 8'(8'h40 + k), 8'h00, 1'b0));
        dma_q.push_back(mk(1'b0, 8'h33, 8'h00, 1'b0));
        drive_masters();
        count_until_dma(cb, lc, da);
        check_output("t2_cpu_before_dma", 8'(cb), 8'd2);
        check_output("t2_dma_granted",    8'(da >= 0), 8'd1);
        idle_cycles(20);

        // Locked DMA burst of 12 writes: 8 back-to-back, one idle, then the rest.
        for (int k = 0; k < 12; k++) dma_q.push_back(mk(1'b1, 8'(8'h20 + k), 8'(8'hC0 + k), 1'b1));
        drive_masters();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dma_gnt) g.push_back(i);
        end
        check_output("t3_grants", 8'(g.size()), 8'd12);
        if (g.size() >= 9) begin
            check_output("t3_first8_span", 8'(g[7] - g[0]), 8'd7);
            check_output("t3_gap",         8'(g[8] - g[7]), 8'd2);
        end
        for (int k = 0; k < 12; k++) check_output("t3_mem", ram_mem[8'h20 + k], 8'(8'hC0 + k));
        idle_cycles(4);

        // Rejected accesses: status write and out-of-window read.
        cpu_q.push_back(mk(1'b1, 8'h00, 8'hEE, 1'b0));
        dma_q.push_back(mk(1'b0, 8'h80, 8'h00, 1'b0));
        drive_masters();
        cnt_ce = 0; cnt_de = 0; cnt_str = 0; cnt_rv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt_ce += int'(cpu_err & cpu_gnt);
            cnt_de += int'(dma_err & dma_gnt);
            cnt_str += int'(ram_wr_en | ram_rd_en);
            cnt_rv += int'(cpu_rvalid | dma_rvalid);
        end
        check_output("t4_cpu_err", 8'(cnt_ce), 8'd1);
        check_output("t4_dma_err", 8'(cnt_de), 8'd1);
        check_output("t4_strobes", 8'(cnt_str), 8'd0);
        check_output("t4_rvalid",  8'(cnt_rv), 8'd0);
        check_output("t4_status",  ram_mem[0], 8'd3);
        idle_cycles(4);

        // Locked CPU burst yields once the waiting DMA starves.
        for (int k = 0; k < 10; k++) cpu_q.push_back(mk(1'b1, 8'(8'h50 + k), 8'(k * 3), 1'b1));
        dma_q.push_back(mk(1'b0, 8'h30, 8'h00, 1'b0));
        drive_masters();
        count_until_dma(cb, lc, da);
        check_output("t5_cpu_before_dma", 8'(cb), 8'd4);
        check_output("t5_dma_delay",      8'(da - lc), 8'd2);
        idle_cycles(30);

        // Reset while a DMA read is waiting for its data.
        dma_q.push_back(mk(1'b0, 8'h21, 8'h00, 1'b0));
        drive_masters();
        tick();
        tick();
        check_output("t6_dma_gnt", 8'(dma_gnt), 8'd1);
        reset = 1'b1;
        tick();
        check_output("t6_no_rvalid", 8'(dma_rvalid), 8'd0);
        check_output("t6_dma_rdata", dma_rdata, 8'd0);
        check_output("t6_rd_en",     8'(ram_rd_en), 8'd0);
        reset = 1'b0;
        cpu_q.push_back(mk(1'b0, 8'h22, 8'h00, 1'b0));
        drive_masters();
        tick();
        check_output("t6_gnt_early", 8'(cpu_gnt), 8'd0);
        tick();
        check_output("t6_gnt", 8'(cpu_gnt), 8'd1);
        idle_cycles(4);

        // Random traffic with occasional withdrawals and resets.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (cpu_q.size() < 4 && $urandom_range(0, 5) == 0) cpu_q.push_back(rand_txn());
            if (dma_q.size() < 4 && $urandom_range(0, 7) == 0) dma_q.push_back(rand_txn());
            reset = ($urandom_range(0, 399) == 0);
            drive_masters();
            tick();
        end
        reset = 1'b0;
        rand_mode = 1'b0;
        idle_cycles(60);
        check_output("drain_cpu_q", 8'(cpu_q.size()), 8'd0);
        check_output("drain_dma_q", 8'(dma_q.size()), 8'd0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
